rr_term_arbiter: RTL and testbench
==================================

# rr_term_arbiter

Four-input round-robin arbiter that drains the terminal-side interface emulators of one mesh router node. It consumes the pending/pop handshake those emulators present (`pndng_i`, `Data_out_i`, `pop_i`, `Trn`) and forwards one packet per grant into a single registered output stage (`push_i`, `Data_in_i`) toward the router's internal path. It fills the arbitration slot of the node emulator, the reading end of the emulators' pop interface.

## Interface
- `pckg_sz`, 40, packet width in bits; bits [pckg_sz-1:pckg_sz-8] carry the destination id.
- `NPORT`, 4, number of arbitrated inputs; fixed at 4, so `Trn` is 2 bits.
- `CNT_W`, 16, width of the forwarded-packet counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pndng_i`  in  [NPORT]  per-port pending flag; head of that port's queue is valid.
- `Data_out_i`  in  [NPORT][pckg_sz]  per-port head packet, show-ahead.
- `stall`  in  1  downstream cannot accept a push this cycle.
- `Trn`  out  2  index of the port granted this cycle; combinational.
- `pop_i`  out  1  pop strobe; the emulator whose id equals `Trn` pops.
- `push_i`  out  1  `Data_in_i` is valid and is delivered this cycle.
- `Data_in_i`  out  pckg_sz  registered packet.
- `src_o`  out  2  source port of the packet on `Data_in_i`.
- `fwd_cnt`  out  CNT_W  packets delivered since reset, wraps.

## Operation
- State: round-robin pointer `ptr`[1:0], output register (`out_vld`, data, src), `last_vld`/`last_port` (port granted in the previous cycle), and `fwd_cnt`.
- Eligibility: a port is eligible when `pndng_i[k]=1` and it is not `last_port` while `last_vld=1`. A port popped in cycle N is ineligible in N+1 because its registered `pndng` lags the queue by one cycle.
- Slot free: `out_vld=0`, or `push_i=1` in the same cycle.
- Grant, combinational: if the slot is free and any port is eligible, the winner is the first eligible port scanning `ptr`, `ptr+1`, ... mod 4. Then `pop_i=1` and `Trn`=winner. Otherwise `pop_i=0` and `Trn` holds `ptr`.
- On a grant clock edge:
  - out data <= `Data_out_i[winner]`, src <= winner, `out_vld` <= 1
  - `ptr` <= winner+1 mod 4
  - `last_vld` <= 1, `last_port` <= winner
- With no grant: `last_vld` <= 0.
- `push_i = out_vld & ~stall`.
- On push with no refill: `out_vld` <= 0.
- On push: `fwd_cnt` <= `fwd_cnt`+1, mod 2^CNT_W.
- Under stall: data, src and `out_vld` hold; no grant, since the slot is not free.
- The destination id is not inspected. Routing happens downstream.

## Timing
- Reset values (async assert, sync-free release):
  - `push_i`=0, `Data_in_i`=0, `src_o`=0, `fwd_cnt`=0
  - `ptr`=0, `last_vld`=0
  - `pop_i`=0, `Trn`=0
- Latency: pop in cycle N, then `push_i` in N+1 if `stall`=0.
- Throughput: 1 packet/cycle when two or more ports alternate. A single active port gets 1 packet per 2 cycles.
- Stall: the packet is held indefinitely. Exactly one push per packet; never duplicated or dropped.
- Simultaneous push and grant: new data replaces the delivered packet at the same edge.
- Reset mid-transfer: a held packet is discarded, and the pointer restarts at 0.

## Structure
- Shared package: `PCKG_SZ` default, `NPORT`, a `port_idx_t` typedef (2-bit), and the destination-id field slice constants.
- One sub-module, `rr_pick4`: combinational 4-way round-robin pick. Inputs: request vector and pointer. Outputs: winner index and valid.

## Test plan
- Single port: port 2 pending with 3 packets (0xA1, 0xA2, 0xA3) -> pops at cycles 0, 2, 4 with `Trn`=2; pushes at 1, 3, 5 in order; `src_o`=2; `fwd_cnt`=3.
- All four ports continuously pending after reset -> grant order 0,1,2,3,0; `push_i` high every cycle from cycle 1.
- Stall: `stall`=1 for 5 cycles while `out_vld`=1 -> `pop_i`=0, `Data_in_i` stable. Release gives exactly one push of the held packet.
- Ports 1 and 3 pending with ptr=2 -> port 3 granted first, then port 1; ptr=2 after both.
- Async reset (`rst`=0) mid-stall with a packet held -> `push_i`, `Data_in_i`, `fwd_cnt` go to 0 immediately with no clock edge; the next grant starts from port 0.
- `fwd_cnt` at 0xFFFF plus one push -> reads 0x0000.

Source files
------------

// File: rtl/rr_term_arbiter_pkg.sv
// Shared types and constants for the terminal-side round-robin arbiter.
// The packet layout and port count here are common to the top and the pick logic.
package rr_term_arbiter_pkg;

    localparam int PCKG_SZ   = 40;
    localparam int NPORT     = 4;
    localparam int CNT_W_DEF = 16;

    // Destination id occupies the top byte of every packet.
    localparam int DEST_MSB  = PCKG_SZ - 1;
    localparam int DEST_LSB  = PCKG_SZ - 8;

    typedef logic [1:0] port_idx_t;

    function automatic logic [NPORT-1:0] port_onehot(input port_idx_t idx);
        port_onehot      = '0;
        port_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_term_arbiter_pick4.sv
// Combinational 4-way round-robin pick: first requester at or after ptr_i, wrapping.
module rr_pick4
    import rr_term_arbiter_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  port_idx_t        ptr_i,
    output port_idx_t        win_o,
    output logic             vld_o
);

    port_idx_t cand;

    always_comb begin
        win_o = ptr_i;
        vld_o = 1'b0;
        cand  = ptr_i;
        for (int i = 0; i < NPORT; i++) begin
            // 2-bit addition wraps naturally past port 3.
            cand = ptr_i + port_idx_t'(i);
            if (!vld_o && req_i[cand]) begin
                vld_o = 1'b1;
                win_o = cand;
            end
        end
    end

endmodule

// File: rtl/rr_term_arbiter.sv
// Round-robin arbiter draining four terminal emulators into one registered
// output slot; one pop per grant, one push per delivered packet.
module rr_term_arbiter
    import rr_term_arbiter_pkg::*;
#(
    parameter int pckg_sz = PCKG_SZ,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORT-1:0]              pndng_i,
    input  logic [NPORT-1:0][pckg_sz-1:0] Data_out_i,
    input  logic                          stall,
    output port_idx_t                     Trn,
    output logic                          pop_i,
    output logic                          push_i,
    output logic [pckg_sz-1:0]            Data_in_i,
    output port_idx_t                     src_o,
    output logic [CNT_W-1:0]              fwd_cnt
);

    port_idx_t          ptr_q, ptr_d;
    logic               out_vld_q, out_vld_d;
    logic [pckg_sz-1:0] data_q, data_d;
    port_idx_t          src_q, src_d;
    logic               last_vld_q, last_vld_d;
    port_idx_t          last_port_q, last_port_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NPORT-1:0]   elig;
    logic               slot_free;
    logic               grant;
    port_idx_t          pick_win;
    logic               pick_vld;

    // The port popped last cycle still shows its stale pending flag; mask it.
    assign elig      = pndng_i & ~(last_vld_q ? port_onehot(last_port_q) : '0);
    assign push_i    = out_vld_q & ~stall;
    assign slot_free = ~out_vld_q | push_i;

    rr_pick4 u_pick (
        .req_i (elig),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .vld_o (pick_vld)
    );

    // Gated by reset so no emulator pops while the arbiter is held in reset.
    assign grant     = rst & slot_free & pick_vld;
    assign pop_i     = grant;
    assign Trn       = grant ? pick_win : ptr_q;
    assign Data_in_i = data_q;
    assign src_o     = src_q;
    assign fwd_cnt   = cnt_q;

    always_comb begin
        ptr_d       = ptr_q;
        out_vld_d   = out_vld_q;
        data_d      = data_q;
        src_d       = src_q;
        last_vld_d  = 1'b0;
        last_port_d = last_port_q;
        cnt_d       = cnt_q;

        if (push_i) begin
            out_vld_d = 1'b0;
            cnt_d     = cnt_q + 1'b1;
        end

        // A refill at the same edge as a push replaces the delivered packet.
        if (grant) begin
            data_d      = Data_out_i[pick_win];
            src_d       = pick_win;
            out_vld_d   = 1'b1;
            ptr_d       = pick_win + 2'd1;
            last_vld_d  = 1'b1;
            last_port_d = pick_win;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            out_vld_q   <= 1'b0;
            data_q      <= '0;
            src_q       <= '0;
            last_vld_q  <= 1'b0;
            last_port_q <= '0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_vld_q   <= out_vld_d;
            data_q      <= data_d;
            src_q       <= src_d;
            last_vld_q  <= last_vld_d;
            last_port_q <= last_port_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_term_arbiter.sv
// Bench for rr_term_arbiter: terminal emulator driver, behavioural arbiter
// model with a slot scoreboard, directed literal checks and a random phase.
module tb_rr_term_arbiter;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       pndng_i;
    logic [3:0][39:0] Data_out_i;
    logic             stall;
    logic [1:0]       Trn;
    logic             pop_i;
    logic             push_i;
    logic [39:0]      Data_in_i;
    logic [1:0]       src_o;
    logic [15:0]      fwd_cnt;

    always #5 clk = ~clk;

    rr_term_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pndng_i    (pndng_i),
        .Data_out_i (Data_out_i),
        .stall      (stall),
        .Trn        (Trn),
        .pop_i      (pop_i),
        .push_i     (push_i),
        .Data_in_i  (Data_in_i),
        .src_o      (src_o),
        .fwd_cnt    (fwd_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- emulator driver ----------------
    int          rem [4];
    logic [39:0] head [4];
    bit          rnd_mode = 1'b0;
    logic        dut_pop  = 1'b0;
    logic [1:0]  dut_trn  = 2'd0;

    task automatic set_inputs();
        for (int k = 0; k < 4; k++) begin
            pndng_i[k]    = (rem[k] > 0);
            Data_out_i[k] = head[k];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (dut_pop && rem[dut_trn] > 0) begin
            rem[dut_trn]--;
            head[dut_trn] = rnd_mode ? {8'($urandom_range(0, 255)), 32'($urandom)}
                                     : head[dut_trn] + 40'd1;
        end
        if (rnd_mode) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 3) == 0 && rem[k] < 6)
                    rem[k] += $urandom_range(1, 3);
            stall = ($urandom_range(0, 3) == 0);
        end
        set_inputs();
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        stall    = 1'b0;
        rnd_mode = 1'b0;
        for (int k = 0; k < 4; k++) rem[k] = 0;
        set_inputs();
        repeat (2) cycle();
        rst = 1'b1;
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    int          m_ptr  = 0;
    int          m_last = -1;
    int          m_win;
    int          m_k;
    bit          m_found;
    bit          e_pop;
    bit          e_push;
    logic [15:0] m_cnt  = 16'd0;
    logic [41:0] exp_q[$];

    always @(negedge clk) begin
        dut_pop = pop_i;
        dut_trn = Trn;
        if (!rst) begin
            m_ptr  = 0;
            m_last = -1;
            m_cnt  = 16'd0;
            exp_q.delete();
            chk("rst_push", push_i, 0);
            chk("rst_pop", pop_i, 0);
            chk("rst_trn", Trn, 0);
            chk("rst_data", Data_in_i, 0);
            chk("rst_src", src_o, 0);
            chk("rst_cnt", fwd_cnt, 0);
        end else begin
            m_found = 1'b0;
            m_win   = 0;
            for (int i = 0; i < 4; i++) begin
                m_k = (m_ptr + i) % 4;
                if (!m_found && pndng_i[m_k] && m_k != m_last) begin
                    m_found = 1'b1;
                    m_win   = m_k;
                end
            end
            e_push = (exp_q.size() > 0) && !stall;
            e_pop  = m_found && ((exp_q.size() == 0) || !stall);
            chk("pop", pop_i, e_pop);
            chk("trn", Trn, e_pop ? m_win : m_ptr);
            chk("push", push_i, e_push);
            chk("cnt", fwd_cnt, m_cnt);
            if (exp_q.size() > 0) chk("pkt", {src_o, Data_in_i}, exp_q[0]);
            if (e_push) begin
                void'(exp_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (e_pop) begin
                exp_q.push_back({2'(m_win), Data_out_i[m_win]});
                m_ptr  = (m_win + 1) % 4;
                m_last = m_win;
            end else begin
                m_last = -1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rem[k]  = 5;
            head[k] = 40'd0;
        end
        set_inputs();

        // Reset with every port pending: nothing pops, outputs at zero.
        repeat (2) cycle();
        #3;
        chk("lit_rst_pop", pop_i, 0);
        chk("lit_rst_trn", Trn, 0);
        chk("lit_rst_push", push_i, 0);
        chk("lit_rst_cnt", fwd_cnt, 0);

        // Single port 2 with three packets: alternate pop / push.
        apply_reset();
        rem[2]  = 3;
        head[2] = 40'hA1;
        set_inputs();
        for (int c = 0; c < 6; c++) begin
            #3;
            chk("lit_single_pop", pop_i, (c % 2 == 0));
            chk("lit_single_trn", Trn, (c % 2 == 0) ? 2 : 3);
            chk("lit_single_push", push_i, (c % 2 == 1));
            if (c % 2 == 1) begin
                chk("lit_single_data", Data_in_i, 40'hA1 + 40'(c / 2));
                chk("lit_single_src", src_o, 2);
            end
            cycle();
        end
        #3;
        chk("lit_single_cnt", fwd_cnt, 3);
        chk("lit_single_idle", pop_i, 0);
        cycle();

        // All four ports pending: grants 0,1,2,3,0, push every cycle from 1.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            rem[k]  = 20;
            head[k] = {8'(k + 1), 32'h0000_0100};
        end
        set_inputs();
        for (int c = 0; c < 5; c++) begin
            #3;
            chk("lit_all_trn", Trn, c % 4);
            chk("lit_all_pop", pop_i, 1);
            chk("lit_all_push", push_i, (c > 0));
            cycle();
        end

        // Stall five cycles with the slot full, then exactly one delivery.
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #3;
            chk("lit_stall_pop", pop_i, 0);
            chk("lit_stall_push", push_i, 0);
            cycle();
        end
        stall = 1'b0;
        #3;
        chk("lit_release_push", push_i, 1);
        repeat (3) cycle();

        // Ports 1 and 3 pending with the pointer at 2.
        apply_reset();
        rem[1] = 1;
        set_inputs();
        repeat (4) cycle();
        rem[1] = 1;
        rem[3] = 1;
        set_inputs();
        #3;
        chk("lit_p13_first", Trn, 3);
        cycle();
        #3;
        chk("lit_p13_second", Trn, 1);
        chk("lit_p13_pop", pop_i, 1);
        cycle();
        #3;
        chk("lit_p13_ptr", Trn, 2);
        cycle();

        // Random traffic and stalls, then drain.
        apply_reset();
        rnd_mode = 1'b1;
        repeat (3000) cycle();
        rnd_mode = 1'b0;
        stall    = 1'b0;
        for (int k = 0; k < 4; k++) rem[k] = 0;
        set_inputs();
        repeat (10) cycle();

        // Asynchronous reset while a packet is held under stall.
        for (int k = 0; k < 4; k++) rem[k] = 10;
        set_inputs();
        repeat (3) cycle();
        stall = 1'b1;
        repeat (2) cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("lit_async_push", push_i, 0);
        chk("lit_async_data", Data_in_i, 0);
        chk("lit_async_src", src_o, 0);
        chk("lit_async_cnt", fwd_cnt, 0);
        chk("lit_async_pop", pop_i, 0);
        repeat (2) cycle();
        stall = 1'b0;
        rst   = 1'b1;
        #3;
        chk("lit_async_restart_trn", Trn, 0);
        chk("lit_async_restart_pop", pop_i, 1);
        cycle();

        // Forwarded-packet counter wraps from 0xFFFF to 0.
        apply_reset();
        for (int k = 0; k < 4; k++) rem[k] = 20000;
        set_inputs();
        repeat (65536) cycle();
        #3;
        chk("lit_wrap_max", fwd_cnt, 16'hFFFF);
        chk("lit_wrap_push", push_i, 1);
        cycle();
        #3;
        chk("lit_wrap_zero", fwd_cnt, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
